// File: rtl/reg_write_seq.sv
// reg_write_seq: byte-stream instruction sequencer driving a 4x8 register file.
// Decodes LDI/MOV/ADD/SUB, reads operands, writes results, updates Z/C flags.
module reg_write_seq #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    output logic          rf_we,
    input  logic [DW-1:0] rf_rdata,
    output logic          flag_z,
    output logic          flag_c,
    output logic          done,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
        IMM,
        RD_SRC,
        RD_DST,
        WR
    } state_t;

    typedef enum logic [1:0] {
        OP_LDI,
        OP_MOV,
        OP_ADD,
        OP_SUB
    } op_t;

    state_t        state;
    state_t        state_nx;
    op_t           op;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [DW-1:0] result;
    logic          carry;
    logic          xfer;
    logic [DW:0]   alu;
    logic          lint_unused;

    assign xfer     = in_valid && in_ready;
    assign rf_wdata = result;

    // opB is kept for observability only; reserved opcode bits are ignored
    assign lint_unused = ^{in_data[1:0], opb};

    // dst op src, evaluated while dst is on the read port; MSB is carry/borrow
    always_comb begin
        alu = '0;
        if (op == OP_SUB) begin
            alu = {1'b0, rf_rdata} - {1'b0, opa};
        end else begin
            alu = {1'b0, rf_rdata} + {1'b0, opa};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and per-state register file controls
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        rf_addr  = '0;
        rf_we    = 1'b0;
        done     = 1'b0;
        busy     = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    if (in_data[7:6] == OP_LDI) begin
                        state_nx = IMM;
                    end else begin
                        state_nx = RD_SRC;
                    end
                end
            end
            IMM: begin
                in_ready = 1'b1;
                rf_addr  = dst;
                if (in_valid) begin
                    state_nx = WR;
                end
            end
            RD_SRC: begin
                rf_addr = src;
                if (op == OP_MOV) begin
                    state_nx = WR;
                end else begin
                    state_nx = RD_DST;
                end
            end
            RD_DST: begin
                rf_addr  = dst;
                state_nx = WR;
            end
            WR: begin
                rf_addr  = dst;
                rf_we    = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand capture, result computation and flag update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op     <= OP_LDI;
            dst    <= '0;
            src    <= '0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            carry  <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) begin
                        op  <= op_t'(in_data[7:6]);
                        dst <= in_data[5:4];
                        src <= in_data[3:2];
                    end
                end
                IMM: begin
                    if (xfer) begin
                        result <= in_data;
                    end
                end
                RD_SRC: begin
                    opa <= rf_rdata;
                    if (op == OP_MOV) begin
                        result <= rf_rdata;
                    end
                end
                RD_DST: begin
                    opb    <= rf_rdata;
                    result <= alu[DW-1:0];
                    carry  <= alu[DW];
                end
                WR: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        flag_z <= (result == '0);
                        flag_c <= carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_seq.sv
// tb_reg_write_seq: directed stimulus with a write scoreboard checked by a
// monitor against a behavioural 4x8 register file.
module tb_reg_write_seq;

    typedef struct packed {
        logic [1:0] a;
        logic [7:0] d;
        logic       z;
        logic       c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [1:0] rf_addr;
    logic [7:0] rf_wdata;
    logic       rf_we;
    logic [7:0] rf_rdata;
    logic       flag_z;
    logic       flag_c;
    logic       done;
    logic       busy;

    logic [7:0] regs [4] = '{default: 8'h00};
    exp_t       sbq [$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;

    reg_write_seq #(.DW(8), .AW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .rf_we    (rf_we),
        .rf_rdata (rf_rdata),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural register file: combinational read, write on rising edge
    assign rf_rdata = regs[rf_addr];
    always @(posedge clk) begin
        if (rf_we) regs[rf_addr] <= rf_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [1:0] a, input logic [7:0] d,
                             input logic z, input logic c);
        exp_t e;
        e.a = a;
        e.d = d;
        e.z = z;
        e.c = c;
        sbq.push_back(e);
    endtask

    // Present one byte; hold keeps in_valid high afterwards
    task automatic send(input logic [7:0] b, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 1);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    task automatic wait_done(input int lat, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 10);
        chk(nm, 32'(n), 32'(lat));
    endtask

    // Track an ADD/SUB after its opcode transfer: src read, dst read, write
    task automatic track_alu(input logic [1:0] s, input logic [1:0] d,
                             input string nm);
        @(negedge clk);
        chk({nm, "_src_addr"}, 32'(rf_addr), 32'(s));
        chk({nm, "_src_rdy"}, 32'(in_ready), 0);
        @(negedge clk);
        chk({nm, "_dst_addr"}, 32'(rf_addr), 32'(d));
        chk({nm, "_dst_rdy"}, 32'(in_ready), 0);
        @(negedge clk);
        chk({nm, "_wr_done"}, 32'(done), 1);
    endtask

    // Monitor: every write is matched to the oldest expected write
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done && !rf_we) begin
                chk("done_without_we", 32'(done), 0);
            end
            if (rf_we) begin
                done_cnt++;
                chk("wr_done", 32'(done), 1);
                chk("wr_ready", 32'(in_ready), 0);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%02h expected none",
                             rf_addr, rf_wdata);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_addr", 32'(rf_addr), 32'(e.a));
                    chk("wr_data", 32'(rf_wdata), 32'(e.d));
                    @(negedge clk);
                    chk("we_pulse", 32'(rf_we), 0);
                    chk("flag_z", 32'(flag_z), 32'(e.z));
                    chk("flag_c", 32'(flag_c), 32'(e.c));
                end
            end
        end
    end

    initial begin
        int n0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(rf_we), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(rf_addr), 0);
        chk("rst_wdata", 32'(rf_wdata), 0);
        chk("rst_z", 32'(flag_z), 0);
        chk("rst_c", 32'(flag_c), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 1);

        // LDI r1, 0x06
        expect_wr(2'd1, 8'h06, 1'b0, 1'b0);
        send(8'h10, 1'b0);
        send(8'h06, 1'b0);
        wait_done(1, "ldi_lat");

        // Preload r2=FF, r3=01, then ADD r2,r3 -> 00 with z=1 c=1
        expect_wr(2'd2, 8'hFF, 1'b0, 1'b0);
        send(8'h20, 1'b0);
        send(8'hFF, 1'b0);
        wait_done(1, "ldi_r2_lat");
        expect_wr(2'd3, 8'h01, 1'b0, 1'b0);
        send(8'h30, 1'b0);
        send(8'h01, 1'b0);
        wait_done(1, "ldi_r3_lat");
        expect_wr(2'd2, 8'h00, 1'b1, 1'b1);
        send(8'hAC, 1'b0);
        track_alu(2'd3, 2'd2, "add");

        // r0=03, r1=05; SUB r0,r1 -> FE c=1; SUB r1,r1 -> 00 z=1
        expect_wr(2'd0, 8'h03, 1'b1, 1'b1);
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        wait_done(1, "ldi_r0_lat");
        expect_wr(2'd1, 8'h05, 1'b1, 1'b1);
        send(8'h10, 1'b0);
        send(8'h05, 1'b0);
        wait_done(1, "ldi_r1_lat");
        expect_wr(2'd0, 8'hFE, 1'b0, 1'b1);
        send(8'hC4, 1'b0);
        wait_done(3, "sub_lat");
        expect_wr(2'd1, 8'h00, 1'b1, 1'b0);
        send(8'hD4, 1'b0);
        wait_done(3, "subself_lat");

        // r0=5A; MOV r3<=r0, flags unchanged
        expect_wr(2'd0, 8'h5A, 1'b1, 1'b0);
        send(8'h00, 1'b0);
        send(8'h5A, 1'b0);
        wait_done(1, "ldi_5a_lat");
        expect_wr(2'd3, 8'h5A, 1'b1, 1'b0);
        send(8'h70, 1'b0);
        wait_done(2, "mov_lat");

        // Immediate stall: LDI r2 then 5 idle cycles
        send(8'h20, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_busy", 32'(busy), 1);
            chk("stall_ready", 32'(in_ready), 1);
            chk("stall_we", 32'(rf_we), 0);
            chk("stall_addr", 32'(rf_addr), 2);
        end
        expect_wr(2'd2, 8'h77, 1'b1, 1'b0);
        send(8'h77, 1'b0);
        wait_done(1, "stall_lat");

        // ADD r1,r0 interrupted by reset in RD_DST
        send(8'h90, 1'b0);
        @(negedge clk);
        chk("mid_src_addr", 32'(rf_addr), 0);
        @(negedge clk);
        chk("mid_dst_addr", 32'(rf_addr), 1);
        rst = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_we", 32'(rf_we), 0);
        chk("mid_addr", 32'(rf_addr), 0);
        chk("mid_wdata", 32'(rf_wdata), 0);
        chk("mid_z", 32'(flag_z), 0);
        chk("mid_c", 32'(flag_c), 0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_hold_we", 32'(rf_we), 0);
        end
        rst = 1'b1;
        expect_wr(2'd3, 8'h42, 1'b0, 1'b0);
        send(8'h30, 1'b0);
        send(8'h42, 1'b0);
        wait_done(1, "post_rst_ldi_lat");

        // Back-to-back stream with in_valid held high
        @(negedge clk);
        n0 = done_cnt;
        expect_wr(2'd0, 8'h11, 1'b0, 1'b0);
        expect_wr(2'd1, 8'h22, 1'b0, 1'b0);
        expect_wr(2'd0, 8'h33, 1'b0, 1'b0);
        send(8'h00, 1'b1);
        send(8'h11, 1'b1);
        send(8'h10, 1'b1);
        send(8'h22, 1'b1);
        send(8'h84, 1'b0);
        track_alu(2'd1, 2'd0, "b2b");
        repeat (2) @(negedge clk);
        chk("b2b_done_cnt", 32'(done_cnt - n0), 3);
        chk("b2b_r0", 32'(regs[0]), 'h33);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_write_seq.md
Name: reg_write_seq

Overview:
- Multi-cycle instruction sequencer directly upstream of the 4x8 register file (`registers`).
- Accepts 8-bit instruction bytes over a valid/ready stream and decodes them.
- Reads operands through the register file's combinational read port (address in, data out in the same cycle).
- Computes LDI/MOV/ADD/SUB results and drives the register file address, data and write-enable.

Parameters:
- DW, 8, data/register width (register file is 8 bits; only 8 is verified)
- AW, 2, register address width (4 registers)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- in_valid  input  1  instruction/immediate byte available
- in_data  input  DW  instruction or immediate byte
- in_ready  output  1  sequencer can accept a byte this cycle
- rf_addr  output  AW  register file address (read and write)
- rf_wdata  output  DW  register file write data
- rf_we  output  1  register file write enable, one-cycle pulse
- rf_rdata  input  DW  register file read data for rf_addr (combinational)
- flag_z  output  1  zero flag
- flag_c  output  1  carry/borrow flag
- done  output  1  one-cycle pulse, coincident with rf_we
- busy  output  1  high whenever state != IDLE

Behaviour:
- Instruction byte fields:
  - [7:6] opcode: 00 LDI, 01 MOV, 10 ADD, 11 SUB.
  - [5:4] dst; [3:2] src; [1:0] reserved, ignored.
- LDI: the next accepted byte is the immediate; dst <= imm.
- MOV: dst <= src.
- ADD: dst <= dst + src.
- SUB: dst <= dst - src.
- States: IDLE, IMM, RD_SRC, RD_DST, WR.
- A byte transfers on a rising edge when in_valid && in_ready.
- in_ready = 1 only in IDLE and IMM.
- IDLE:
  - rf_addr = 0.
  - On transfer: latch opcode, dst and src.
  - LDI -> IMM; MOV/ADD/SUB -> RD_SRC.
  - Without in_valid: stay in IDLE.
- IMM:
  - rf_addr = dst.
  - Waits indefinitely for in_valid; on transfer latch result = in_data -> WR.
- RD_SRC:
  - rf_addr = src; latch rf_rdata into opA.
  - MOV -> WR with result = opA; ADD/SUB -> RD_DST.
- RD_DST:
  - rf_addr = dst; latch rf_rdata into opB.
  - Compute the (DW+1)-bit value {c,result}: opB + opA for ADD, opB - opA for SUB.
  - -> WR.
- WR:
  - rf_addr = dst, rf_we = 1, done = 1, rf_wdata = result.
  - -> IDLE; no byte is accepted in WR.
- rf_wdata is a register holding the last result; it stays stable outside WR.
- rf_we and done are high only in WR; rf_addr is decoded from the state.
- Latency in cycles (T = cycle of opcode transfer):
  - MOV: write at T+2.
  - ADD/SUB: write at T+3.
  - LDI: write at I+1 (I = cycle of immediate transfer).
  - Back-to-back throughput is one instruction per 3/4 cycles; a new opcode can transfer the cycle after WR.
- Flags are updated on the WR edge:
  - ADD/SUB: flag_z = (result == 0).
  - ADD: flag_c = carry out of bit DW-1.
  - SUB: flag_c = borrow (opB < opA).
  - LDI/MOV: both flags unchanged.
- Arithmetic wraps modulo 2^DW.
- dst == src is legal: ADD doubles the value; SUB yields 0 with z=1, c=0.
- Reset (rst low, asynchronous):
  - State -> IDLE; rf_we, done and busy = 0.
  - rf_addr = 0; rf_wdata = 0; flag_z = 0; flag_c = 0; opA = opB = 0.
  - in_ready = 1 once rst is released.
- Reset asserted mid-instruction, including in WR: no write is issued after assertion, and the partial instruction is discarded.
- No X propagation: in_data is ignored when in_valid = 0.

Test Plan:
- Reset then LDI:
  - Stimulus: hold rst=0 and check outputs are 0 and busy=0; release; send 0x10 (LDI r1), then 0x06.
  - Required: rf_we for exactly 1 cycle with rf_addr=1, rf_wdata=0x06; flags unchanged (0,0).
- ADD with carry:
  - Stimulus: model register file holds r2=0xFF, r3=0x01; send 0xAC (ADD dst=r2, src=r3).
  - Required: RD_SRC drives rf_addr=3, RD_DST drives rf_addr=2; write at T+3 of r2=0x00 with z=1, c=1.
- SUB borrow and self-SUB:
  - SUB r0-r1 with r0=0x03, r1=0x05 -> r0=0xFE, c=1, z=0.
  - SUB r1-r1 -> r1=0x00, z=1, c=0.
- MOV and stall:
  - MOV r3<=r0 (byte 0x70) with r0=0x5A -> write r3=0x5A at T+2, flags unchanged.
  - Immediate stall: send LDI opcode, hold in_valid=0 for 5 cycles; required: stays in IMM, in_ready=1, no rf_we until the immediate arrives.
- Reset mid-op:
  - Stimulus: assert rst during RD_DST of an ADD.
  - Required: immediate return to IDLE; no rf_we pulse; next LDI executes normally.
- Back-to-back:
  - Stimulus: stream LDI r0,0x11 / LDI r1,0x22 / ADD r0,r1 with in_valid held high.
  - Required: in_ready low in RD_SRC/RD_DST/WR; three writes with the final r0=0x33; done pulses count = 3.
